// File: rtl/noc_pkg.sv
// Shared definitions for the NoC request path: flit layout, type codes and
// the issue FSM state encoding.
package noc_pkg;

  localparam int unsigned FLIT_W   = 12;
  localparam int unsigned TYPE_W   = 2;
  localparam int unsigned DST_W    = 2;
  localparam int unsigned SRC_W    = 2;
  localparam int unsigned PAGE_W   = 6;

  localparam int unsigned PAGE_LSB = 0;
  localparam int unsigned SRC_LSB  = PAGE_LSB + PAGE_W;
  localparam int unsigned DST_LSB  = SRC_LSB + SRC_W;
  localparam int unsigned TYPE_LSB = DST_LSB + DST_W;

  localparam logic [TYPE_W-1:0] TYPE_REQ = 2'b01;
  localparam logic [TYPE_W-1:0] TYPE_RSP = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } issue_state_e;

  // Destination router port is the top two bits of the page id.
  function automatic logic [FLIT_W-1:0] pack_req(input logic [SRC_W-1:0]  src,
                                                 input logic [PAGE_W-1:0] page);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[TYPE_LSB +: TYPE_W] = TYPE_REQ;
    f[DST_LSB  +: DST_W]  = page[PAGE_W-1 -: DST_W];
    f[SRC_LSB  +: SRC_W]  = src;
    f[PAGE_LSB +: PAGE_W] = page;
    return f;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Power-of-two deep request FIFO with wrapping pointers and an occupancy
// count one bit wider than the pointers.
module noc_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full_o
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full_o;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= din;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/noc_requester.sv
// Queues page requests from the engine and issues them as request flits to
// the router, respecting router back-pressure and an outstanding-request cap.
module noc_requester
  import noc_pkg::*;
#(
  parameter int unsigned SRC_ID  = 0,
  parameter int unsigned REQ_W   = 12,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [5:0]       req_page,
  output logic             req_ready,
  input  logic             full,
  input  logic             almost_full,
  input  logic             rsp_done,
  output logic [REQ_W-1:0] data_out,
  output logic             write,
  output logic [2:0]       outstanding,
  output logic             idle
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [2:0]    MAX_C   = 3'(MAX_OUT);
  localparam logic [1:0]    SRC_C   = 2'(SRC_ID);

  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [PAGE_W-1:0] fifo_dout;
  logic              push, do_issue, rsp_take;

  issue_state_e      state_q, state_d;
  logic              ready_q;
  logic              write_q;
  logic [REQ_W-1:0]  data_q, data_d;
  logic [2:0]        out_q, out_d;

  noc_fifo #(
    .W     (PAGE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (do_issue),
    .din    (req_page),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .full_o (fifo_full)
  );

  // ready_q keeps req_ready low until the first edge after reset release.
  assign req_ready   = ready_q && !fifo_full;
  assign push        = req_valid && req_ready;
  assign rsp_take    = rsp_done && (out_q != '0);
  // A response retiring this cycle frees a slot, so the cap is not a stall then.
  assign do_issue    = (state_q == ST_ISSUE) && !fifo_empty && !full &&
                       ((out_q < MAX_C) || rsp_take);

  assign write       = write_q;
  assign data_out    = data_q;
  assign outstanding = out_q;
  assign idle        = fifo_empty && (out_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (do_issue) begin
          if (almost_full)                        state_d = ST_HOLD;
          else if (fifo_count == CNT_ONE && !push) state_d = ST_IDLE;
        end else if (fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!almost_full && !full) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase

    data_d = do_issue ? REQ_W'(pack_req(SRC_C, fifo_dout)) : data_q;

    unique case ({do_issue, rsp_take})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      write_q <= 1'b0;
      data_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      write_q <= do_issue;
      data_q  <= data_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_noc_requester.sv
// Directed bench for noc_requester: requests are scored into a queue when
// accepted and compared in order against each write strobe.
module tb_noc_requester;

  localparam logic [1:0] SRC_BITS = 2'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [5:0]  req_page;
  logic        req_ready;
  logic        full_s;
  logic        af_s;
  logic        rsp_done;
  logic [11:0] data_out;
  logic        write;
  logic [2:0]  outstanding;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  logic [11:0] sb[$];
  logic [11:0] mon_exp;

  always #5 clk = ~clk;

  noc_requester #(
    .SRC_ID  (1),
    .REQ_W   (12),
    .DEPTH   (4),
    .MAX_OUT (4)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .req_valid   (req_valid),
    .req_page    (req_page),
    .req_ready   (req_ready),
    .full        (full_s),
    .almost_full (af_s),
    .rsp_done    (rsp_done),
    .data_out    (data_out),
    .write       (write),
    .outstanding (outstanding),
    .idle        (idle)
  );

  function automatic logic [11:0] exp_flit(input logic [5:0] pg);
    return {2'b01, pg[5:4], SRC_BITS, pg};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic try_send(input logic [5:0] pg, output logic acc);
    req_valid = 1'b1;
    req_page  = pg;
    acc       = req_ready;
    if (acc) sb.push_back(exp_flit(pg));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic pulse_rsp();
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int budget);
    for (int i = 0; i < budget && wr_count < target; i++) tick();
    chk("write_count", wr_count, target);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && write === 1'b1) begin
      wr_count++;
      chk("write_while_full", {31'b0, write & full_s}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_write", {31'b0, write}, 32'd0);
      end else begin
        mon_exp = sb.pop_front();
        chk("flit_order", {20'b0, data_out}, {20'b0, mon_exp});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    logic acc5 [5];
    int w0;
    logic [5:0] pg25 [5];
    pg25[0] = 6'h03; pg25[1] = 6'h1A; pg25[2] = 6'h2C; pg25[3] = 6'h3F; pg25[4] = 6'h11;

    rst_n = 1'b0; req_valid = 1'b0; req_page = '0;
    full_s = 1'b0; af_s = 1'b0; rsp_done = 1'b0;

    #12;
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_data", {20'b0, data_out}, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd1);
    chk("rst_outstanding", {29'b0, outstanding}, 32'd0);

    @(posedge clk); #3;
    rst_n = 1'b1;
    #1 chk("ready_before_edge", {31'b0, req_ready}, 32'd0);
    tick();
    chk("ready_after_edge", {31'b0, req_ready}, 32'd1);

    // Single request: write two cycles after acceptance.
    try_send(6'h25, acc);
    chk("single_acc", {31'b0, acc}, 32'd1);
    chk("lat_cyc0", {31'b0, write}, 32'd0);
    tick();
    chk("lat_cyc1", {31'b0, write}, 32'd0);
    tick();
    chk("lat_cyc2_write", {31'b0, write}, 32'd1);
    chk("single_data", {20'b0, data_out}, 32'h665);
    chk("single_outstanding", {29'b0, outstanding}, 32'd1);
    chk("single_not_idle", {31'b0, idle}, 32'd0);
    tick();
    chk("write_one_cycle", {31'b0, write}, 32'd0);
    chk("data_held", {20'b0, data_out}, 32'h665);
    pulse_rsp();
    chk("rsp_dec", {29'b0, outstanding}, 32'd0);
    chk("idle_after_rsp", {31'b0, idle}, 32'd1);

    // Response with nothing outstanding is ignored.
    pulse_rsp();
    chk("rsp_zero_out", {29'b0, outstanding}, 32'd0);
    chk("rsp_zero_idle", {31'b0, idle}, 32'd1);

    // Five back-to-back requests against a full router.
    full_s = 1'b1;
    w0 = wr_count;
    for (int i = 0; i < 5; i++) try_send(pg25[i], acc5[i]);
    for (int i = 0; i < 4; i++) chk("fill_acc", {31'b0, acc5[i]}, 32'd1);
    chk("fifth_rejected", {31'b0, acc5[4]}, 32'd0);
    chk("ready_low_full", {31'b0, req_ready}, 32'd0);
    repeat (4) tick();
    chk("no_write_while_full", wr_count, w0);
    full_s = 1'b0;
    wait_writes(w0 + 4, 12);
    chk("out_at_max", {29'b0, outstanding}, 32'd4);

    // Outstanding cap: fifth request stalls until a response retires.
    w0 = wr_count;
    try_send(6'h2B, acc);
    chk("cap_acc", {31'b0, acc}, 32'd1);
    repeat (5) tick();
    chk("cap_stall", wr_count, w0);
    chk("cap_out_hold", {29'b0, outstanding}, 32'd4);
    rsp_done = 1'b1;
    tick();
    rsp_done = 1'b0;
    chk("cap_write_next", {31'b0, write}, 32'd1);
    chk("cap_out_same", {29'b0, outstanding}, 32'd4);
    chk("cap_data", {20'b0, data_out}, {20'b0, exp_flit(6'h2B)});
    repeat (4) pulse_rsp();
    chk("cap_drained", {29'b0, outstanding}, 32'd0);

    // almost_full: each write is followed by a HOLD period.
    full_s = 1'b1;
    try_send(6'h05, acc);
    try_send(6'h36, acc);
    try_send(6'h21, acc);
    chk("af_third_acc", {31'b0, acc}, 32'd1);
    w0 = wr_count;
    full_s = 1'b0;
    af_s = 1'b1;
    wait_writes(w0 + 1, 8);
    chk("af_gap1", {31'b0, write}, 32'd0);
    full_s = 1'b1;
    repeat (2) tick();
    chk("af_hold", wr_count, w0 + 1);
    full_s = 1'b0;
    repeat (2) tick();
    chk("af_hold_af", wr_count, w0 + 1);
    af_s = 1'b0;
    tick();
    af_s = 1'b1;
    wait_writes(w0 + 2, 6);
    chk("af_gap2", {31'b0, write}, 32'd0);
    af_s = 1'b0;
    tick();
    af_s = 1'b1;
    wait_writes(w0 + 3, 6);
    af_s = 1'b0;
    tick();
    repeat (3) pulse_rsp();
    chk("af_idle", {31'b0, idle}, 32'd1);

    // Reset with queued requests and outstanding responses.
    w0 = wr_count;
    try_send(6'h0A, acc);
    try_send(6'h3C, acc);
    wait_writes(w0 + 2, 10);
    chk("pre_rst_out", {29'b0, outstanding}, 32'd2);
    full_s = 1'b1;
    try_send(6'h12, acc);
    try_send(6'h27, acc);
    try_send(6'h33, acc);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_write", {31'b0, write}, 32'd0);
    chk("mid_rst_data", {20'b0, data_out}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    chk("mid_rst_idle", {31'b0, idle}, 32'd1);
    chk("mid_rst_out", {29'b0, outstanding}, 32'd0);
    sb.delete();
    full_s = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
    w0 = wr_count;
    repeat (6) tick();
    chk("no_write_after_rst", wr_count, w0);
    chk("idle_after_rst", {31'b0, idle}, 32'd1);

    // Normal operation resumes with a fresh request.
    try_send(6'h3E, acc);
    chk("post_rst_acc", {31'b0, acc}, 32'd1);
    tick();
    tick();
    chk("post_rst_write", {31'b0, write}, 32'd1);
    chk("post_rst_data", {20'b0, data_out}, {20'b0, exp_flit(6'h3E)});
    chk("post_rst_out", {29'b0, outstanding}, 32'd1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_requester.md
NOC_REQUESTER -- requirements
Module: noc_requester

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SRC_ID, 0, this node's router port 0..3
- REQ_W, 12, request flit width
- DEPTH, 4, local request FIFO entries (power of 2)
- MAX_OUT, 4, outstanding request limit
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge
- reset, in, 1, asynchronous, active-low reset
- req_valid, in, 1, engine offers a page request
- req_page, in, 6, requested page id 0..63
- req_ready, out, 1, request accepted when req_valid and req_ready are both high
- full, in, 1, router input port full
- almost_full, in, 1, router input port has one free slot
- rsp_done, in, 1, one response for this node consumed (one-cycle pulse)
- data_out, out, REQ_W, request flit to router
- write, out, 1, flit write strobe, exactly one cycle per flit
- outstanding, out, 3, requests issued but not yet answered
- idle, out, 1, FIFO empty and outstanding==0

Function
REQ-003 Flit format SHALL be {type[1:0]=2'b01, dst[1:0]=req_page[5:4], src[1:0]=SRC_ID, page[5:0]}, MSB first.
REQ-004 Accepted requests SHALL enter a DEPTH-entry FIFO; req_ready SHALL be high iff FIFO count<DEPTH, combinationally, with no dependence on req_valid.
REQ-005 The issue FSM SHALL have states IDLE, ISSUE and HOLD.
REQ-006 IDLE->ISSUE SHALL occur when the FIFO is non-empty.
REQ-007 ISSUE SHALL pulse write and pop the FIFO when full==0 and outstanding<MAX_OUT.
REQ-008 After a write while almost_full==1, the FSM SHALL go to HOLD for at least one cycle, then return to ISSUE once almost_full==0 and full==0.
REQ-009 From ISSUE with the FIFO empty after a pop, the FSM SHALL go to IDLE.
REQ-010 data_out SHALL be registered and valid in the write cycle; it SHALL hold its last value otherwise.
REQ-011 Latency from an accepted request into an empty FIFO to write SHALL be 2 cycles, when the router is not full and outstanding<MAX_OUT.
REQ-012 A simultaneous push and pop SHALL leave the FIFO count unchanged. A push when count==DEPTH SHALL be impossible because req_ready is low.
REQ-013 outstanding SHALL increment on write, decrement on rsp_done, and stay unchanged when both occur in the same cycle.
REQ-014 rsp_done while outstanding==0 SHALL be ignored, and outstanding SHALL never exceed MAX_OUT.
REQ-015 FIFO pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits.
REQ-016 write SHALL never be asserted in a cycle where full==1.

Reset
REQ-017 reset low SHALL asynchronously clear the FIFO, pointers, count and outstanding, and force the FSM to IDLE.
REQ-018 While reset is low, write SHALL be 0, data_out 0, req_ready 0 and idle 1.
REQ-019 Reset asserted mid-issue SHALL discard all queued requests; no write SHALL follow deassertion until a new request is accepted.
REQ-020 Reset deassertion SHALL take effect synchronously; req_ready SHALL rise on the first clk edge after release.

Structure
REQ-021 A shared package noc_pkg SHALL hold the flit field widths and offsets, the type codes (REQ=2'b01, RSP=2'b10) and the FSM state encoding.
REQ-022 The FIFO SHALL be a sub-module noc_fifo with parameters (W, DEPTH) and ports push, pop, din, dout, count, empty and full_o.
REQ-023 The FSM, flit packer and outstanding counter SHALL live in noc_requester.

Verification
REQ-024 Single request, SRC_ID=1, page 6'h25, full=almost_full=0 -> write 2 cycles later with data_out=12'b01_10_01_100101 and outstanding=1.
REQ-025 Five back-to-back requests, DEPTH=4, full=1 held -> req_ready low after the 4th accept and no write; after full=0, four writes in order.
REQ-026 almost_full=1 with 3 queued requests -> writes are separated by at least one HOLD cycle and none occurs while full=1.
REQ-027 Issue 4 requests (MAX_OUT=4) with a 5th queued -> 5th stalls until rsp_done, then writes next cycle; simultaneous write and rsp_done keeps outstanding at 4.
REQ-028 reset low while 3 requests are queued and outstanding=2 -> all cleared, idle=1, no write after release.
REQ-029 rsp_done pulse with outstanding=0 -> outstanding stays 0 and idle stays 1.
